// File: rtl/ladybird_axi_ram.sv
// Single-port word RAM behind an AXI4-Lite-style responder.
// One transaction in flight at a time; writes take priority over reads in IDLE.
module ladybird_axi_ram #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    // Handshake rule: a transfer happens on a rising edge where valid and ready are both 1.
    typedef enum logic [1:0] {IDLE, W_DATA, W_RESP, R_RESP} state_t;

    state_t      state;
    logic [31:0] mem [DEPTH];
    logic [31:0] wr_addr;

    logic [31:0] aw_off;
    logic [31:0] ar_off;
    logic        aw_hit;
    logic        ar_hit;
    logic [AW-1:0] aw_idx;
    logic [AW-1:0] ar_idx;
    logic        w_hs;
    logic        ar_hs;
    logic        aw_hs;

    // Offsets wrap at 32 bits, so addresses below BASE_ADDR land far out of range.
    assign aw_off = wr_addr - BASE_ADDR;
    assign ar_off = araddr - BASE_ADDR;
    assign aw_hit = {1'b0, aw_off} < SPAN;
    assign ar_hit = {1'b0, ar_off} < SPAN;
    assign aw_idx = aw_off[AW+1:2];
    assign ar_idx = ar_off[AW+1:2];

    assign awready = (state == IDLE);
    assign arready = (state == IDLE) && !awvalid;
    assign wready  = (state == W_DATA);

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign ar_hs = arvalid && arready;

    // Storage has no reset; a write coincident with reset is suppressed.
    always_ff @(posedge clk) begin
        if (nrst && w_hs && aw_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[aw_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= IDLE;
            wr_addr <= 32'h0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
            rvalid  <= 1'b0;
            rresp   <= OKAY;
            rdata   <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        wr_addr <= awaddr;
                        state   <= W_DATA;
                    end else if (ar_hs) begin
                        rvalid <= 1'b1;
                        rresp  <= ar_hit ? OKAY : SLVERR;
                        rdata  <= ar_hit ? mem[ar_idx] : 32'h0;
                        state  <= R_RESP;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        bvalid <= 1'b1;
                        bresp  <= aw_hit ? OKAY : SLVERR;
                        state  <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ladybird_axi_ram.sv
// Bench for ladybird_axi_ram: a small RAM model feeds expected-response queues
// that are checked as each response phase is observed.
module tb_ladybird_axi_ram;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_0100;

    logic        clk;
    logic        nrst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks;
    int failures;

    logic [33:0] exp_q[$];
    logic [1:0]  bexp_q[$];
    logic [31:0] model [DEPTH];

    ladybird_axi_ram #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .nrst(nrst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return off < 32'(DEPTH * 4);
    endfunction

    function automatic int word_of(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - BASE) >> 2;
        return int'(off);
    endfunction

    // Full write: AW phase (wvalid already high but must not be taken), W phase, B phase.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [1:0] eb;
        @(negedge clk);
        awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb;
        wvalid = 1'b1; bready = 1'b1; arvalid = 1'b0;
        #1;
        checks++;
        if (awready !== 1'b1) begin
            failures++;
            $display("FAIL wr_awready addr=%h got=%b want=1", addr, awready);
        end
        if (in_range(addr)) begin
            for (int i = 0; i < 4; i++)
                if (strb[i]) model[word_of(addr)][8*i +: 8] = data[8*i +: 8];
            bexp_q.push_back(2'b00);
        end else begin
            bexp_q.push_back(2'b10);
        end
        @(negedge clk);
        awvalid = 1'b0;
        #1;
        checks++;
        if ({wready, bvalid, awready} !== 3'b100) begin
            failures++;
            $display("FAIL wr_data_phase addr=%h got={wready,bvalid,awready}=%b want=100",
                     addr, {wready, bvalid, awready});
        end
        @(negedge clk);
        wvalid = 1'b0;
        #1;
        eb = bexp_q.pop_front();
        checks++;
        if ({bvalid, bresp} !== {1'b1, eb}) begin
            failures++;
            $display("FAIL wr_resp addr=%h got bvalid=%b bresp=%b want bvalid=1 bresp=%b",
                     addr, bvalid, bresp, eb);
        end
    endtask

    // Read with optional rready stall; stall=0 leaves the DUT returning to IDLE at the next edge.
    task automatic do_read(input logic [31:0] addr, input int stall);
        logic [33:0] e;
        @(negedge clk);
        araddr = addr; arvalid = 1'b1; awvalid = 1'b0; rready = (stall == 0);
        #1;
        checks++;
        if (arready !== 1'b1) begin
            failures++;
            $display("FAIL rd_arready addr=%h got=%b want=1", addr, arready);
        end
        if (in_range(addr)) exp_q.push_back({2'b00, model[word_of(addr)]});
        else                exp_q.push_back({2'b10, 32'h0});
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({rvalid, rresp, rdata} !== {1'b1, e}) begin
            failures++;
            $display("FAIL rd_data addr=%h got rvalid=%b rresp=%b rdata=%h want rvalid=1 rresp=%b rdata=%h",
                     addr, rvalid, rresp, rdata, e[33:32], e[31:0]);
        end
        if (stall > 0) begin
            arvalid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk);
                #1;
                checks++;
                if ({rvalid, rresp, rdata, arready} !== {1'b1, e, 1'b0}) begin
                    failures++;
                    $display("FAIL rd_stall cyc=%0d got rvalid=%b rresp=%b rdata=%h arready=%b want 1 %b %h 0",
                             i, rvalid, rresp, rdata, arready, e[33:32], e[31:0]);
                end
            end
            arvalid = 1'b0;
            rready  = 1'b1;
            @(negedge clk);
            #1;
            checks++;
            if ({rvalid, arready} !== 2'b01) begin
                failures++;
                $display("FAIL rd_release got rvalid=%b arready=%b want 0 1", rvalid, arready);
            end
        end
    endtask

    task automatic test_reset;
        nrst = 1'b0; awaddr = 32'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0;
        wvalid = 1'b0; bready = 1'b0; araddr = 32'h0; arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        #1;
        checks++;
        if ({bvalid, rvalid, bresp, rresp, rdata} !== 38'h0) begin
            failures++;
            $display("FAIL reset_outputs got bvalid=%b rvalid=%b bresp=%b rresp=%b rdata=%h want all zero",
                     bvalid, rvalid, bresp, rresp, rdata);
        end
        checks++;
        if ({awready, arready, wready} !== 3'b110) begin
            failures++;
            $display("FAIL reset_readies got {aw,ar,w}=%b want 110", {awready, arready, wready});
        end
    endtask

    task automatic test_fill;
        for (int i = 0; i < DEPTH; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF);
    endtask

    task automatic test_basic;
        do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        do_read(BASE + 32'h10, 0);
        do_write(BASE + 32'h10, 32'h1122_3344, 4'b0101);
        do_read(BASE + 32'h10, 0);
        checks++;
        if (model[4] !== 32'hDE22_BE44) begin
            failures++;
            $display("FAIL partial_model got=%h want=DE22BE44", model[4]);
        end
        do_write(BASE + 32'h10, 32'hFFFF_FFFF, 4'b0000);
        do_read(BASE + 32'h13, 0);
    endtask

    task automatic test_out_of_range;
        do_read(BASE + 32'(DEPTH * 4), 0);
        do_write(BASE + 32'(DEPTH * 4), 32'h1234_5678, 4'hF);
        do_read(BASE, 0);
        do_read(BASE - 32'h4, 0);
        do_write(BASE - 32'h4, 32'h8765_4321, 4'hF);
        do_read(BASE + 32'(DEPTH * 4) - 32'h4, 0);
    endtask

    task automatic test_collision;
        logic [33:0] e;
        @(negedge clk);
        awaddr = BASE + 32'h20; awvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b0;
        araddr = BASE + 32'h20; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        #1;
        checks++;
        if ({awready, arready} !== 2'b10) begin
            failures++;
            $display("FAIL coll_priority got {aw,ar}=%b want 10", {awready, arready});
        end
        model[8] = 32'hCAFE_F00D;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b1;
        #1;
        checks++;
        if ({arready, wready, rvalid} !== 3'b010) begin
            failures++;
            $display("FAIL coll_wdata got {ar,w,rvalid}=%b want 010", {arready, wready, rvalid});
        end
        @(negedge clk);
        wvalid = 1'b0;
        #1;
        checks++;
        if ({bvalid, bresp, arready} !== 4'b1000) begin
            failures++;
            $display("FAIL coll_bresp got bvalid=%b bresp=%b arready=%b want 1 00 0", bvalid, bresp, arready);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({arready, bvalid, rvalid} !== 3'b100) begin
            failures++;
            $display("FAIL coll_ar_accept got {ar,bvalid,rvalid}=%b want 100", {arready, bvalid, rvalid});
        end
        exp_q.push_back({2'b00, model[8]});
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({rvalid, rresp, rdata} !== {1'b1, e}) begin
            failures++;
            $display("FAIL coll_rdata got rvalid=%b rresp=%b rdata=%h want 1 %b %h",
                     rvalid, rresp, rdata, e[33:32], e[31:0]);
        end
    endtask

    task automatic test_read_stall;
        do_read(BASE + 32'h1C, 5);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        awaddr = BASE + 32'h30; awvalid = 1'b1; wdata = 32'h5555_AAAA; wstrb = 4'hF;
        wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b1;
        model[12] = 32'h5555_AAAA;
        @(negedge clk);
        wvalid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bvalid !== 1'b1) begin
            failures++;
            $display("FAIL rst_bvalid_held got=%b want=1", bvalid);
        end
        nrst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({bvalid, awready, rvalid, bresp} !== 5'b01000) begin
            failures++;
            $display("FAIL rst_mid got bvalid=%b awready=%b rvalid=%b bresp=%b want 0 1 0 00",
                     bvalid, awready, rvalid, bresp);
        end
        nrst = 1'b1; bready = 1'b1;
        // W handshake with reset low must leave memory untouched.
        @(negedge clk);
        awaddr = BASE + 32'h30; awvalid = 1'b1; wdata = 32'h0BAD_0BAD;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b1; nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1; wvalid = 1'b0;
        #1;
        checks++;
        if ({bvalid, awready} !== 2'b01) begin
            failures++;
            $display("FAIL rst_wr_abort got bvalid=%b awready=%b want 0 1", bvalid, awready);
        end
        do_read(BASE + 32'h30, 0);
        do_read(BASE + 32'h10, 0);
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = BASE + 32'($urandom_range(0, DEPTH * 4 + 15)) - 32'h4;
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom_range(0, 15)));
            else                           do_read(a, 0);
        end
        for (int i = 0; i < DEPTH; i++) do_read(BASE + 32'(4 * i), 0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_fill;
        test_basic;
        test_out_of_range;
        test_collision;
        test_read_stall;
        test_reset_mid;
        test_back_to_back;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || bexp_q.size() != 0) begin
            failures++;
            $display("FAIL queues_drained got r=%0d b=%0d want 0 0", exp_q.size(), bexp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ladybird_axi_ram.md
LADYBIRD_AXI_RAM -- requirements
Module: ladybird_axi_ram

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning memory size in 32-bit words (power of two, >=2).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0 (aligned to DEPTH*4).
REQ-003 SHALL have ports, one per line, as name direction width meaning:
 clk  input  1  clock, all state updates on rising edge
 nrst  input  1  reset, synchronous, active-low
 awaddr  input  32  write address (byte)
 awvalid  input  1  write address valid
 awready  output  1  write address ready
 wdata  input  32  write data
 wstrb  input  4  byte write strobes, bit i enables wdata[8i+7:8i]
 wvalid  input  1  write data valid
 wready  output  1  write data ready
 bresp  output  2  write response, 2'b00 OKAY, 2'b10 SLVERR
 bvalid  output  1  write response valid
 bready  input  1  write response ready
 araddr  input  32  read address (byte)
 arvalid  input  1  read address valid
 arready  output  1  read address ready
 rdata  output  32  read data
 rresp  output  2  read response, 2'b00 OKAY, 2'b10 SLVERR
 rvalid  output  1  read data valid
 rready  input  1  read data ready

Function
REQ-004 SHALL be an AXI4-Lite-style responder, single beat per transaction, one transaction outstanding at a time.
REQ-005 SHALL implement states IDLE, W_DATA, W_RESP, R_RESP; readies are combinational functions of state and inputs only.
REQ-006 IDLE: awready=1; arready=~awvalid (write wins on simultaneous awvalid and arvalid); wready=0.
REQ-007 AW handshake in IDLE SHALL latch awaddr and go to W_DATA; wvalid in the same cycle SHALL NOT be consumed.
REQ-008 W_DATA: wready=1, awready=arready=0; W handshake SHALL write memory at that edge per wstrb, set bvalid=1 with bresp, go to W_RESP.
REQ-009 W_RESP: all readies 0; bvalid held with stable bresp until bready; on bready clear bvalid, go to IDLE.
REQ-010 AR handshake in IDLE SHALL register rdata/rresp and set rvalid=1 at the next edge (read latency 1 cycle), go to R_RESP.
REQ-011 R_RESP: all readies 0; rvalid, rdata, rresp held stable until rready; on rready clear rvalid, go to IDLE.
REQ-012 Word index SHALL be (addr - BASE_ADDR) >> 2 using log2(DEPTH) bits; addr[1:0] ignored.
REQ-013 Address in range iff (addr - BASE_ADDR), 32-bit unsigned wrap, < DEPTH*4; out of range SHALL give SLVERR, no memory write, rdata=32'h0.
REQ-014 wstrb=4'b0000 in range SHALL give OKAY with no memory change.
REQ-015 Read issued after a completed write to the same word SHALL return the written data (no stale data).
REQ-016 Minimum transaction turnaround: back-to-back reads SHALL complete in 2 cycles each when rready held 1; writes in 3 cycles with wvalid, bready held 1.

Reset
REQ-017 nrst=0 at a rising edge SHALL force state IDLE, bvalid=0, rvalid=0, bresp=2'b00, rresp=2'b00, rdata=32'h0, from any state including mid-transaction.
REQ-018 Memory contents SHALL NOT be cleared by reset; a W handshake coincident with nrst=0 SHALL NOT write memory.

Verification
REQ-019 Write awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, bready=1 -> bvalid one cycle after W handshake, bresp=00; then read 0x10 -> rvalid one cycle after AR, rdata=0xDEADBEEF, rresp=00.
REQ-020 Partial write wstrb=4'b0101, wdata=0x11223344 over 0xDEADBEEF at 0x10 -> read returns 0xDE22BE44.
REQ-021 awvalid and arvalid asserted same cycle in IDLE -> arready=0, write completes first, read accepted only after bvalid&bready.
REQ-022 Read araddr=BASE_ADDR+DEPTH*4 -> rresp=10, rdata=0; write to same address -> bresp=10, word 0 unchanged.
REQ-023 Hold rready=0 for 5 cycles in R_RESP -> rvalid, rdata stable, arready=0 throughout; rready=1 -> IDLE next cycle.
REQ-024 Assert nrst=0 in W_RESP with bvalid=1 -> next cycle bvalid=0, awready=1; memory retains previously written data.
